// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with a double-buffered display word.
// Optional per-digit blinking is compiled in with `define BLINK_EN.
module seg_scan_driver #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        neg,
    input  logic [3:0]  dp,
    input  logic        blank_lz,
`ifdef BLINK_EN
    input  logic [3:0]  blink,
`endif
    output logic        ack,
    output logic        pending,
    output logic [7:0]  seg,
    output logic [3:0]  ena
);

    localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BW = 8;

    typedef struct packed {
        logic [15:0] value;
        logic        neg;
        logic [3:0]  dp;
        logic        blank_lz;
`ifdef BLINK_EN
        logic [3:0]  blink;
`endif
    } word_t;

    localparam word_t WORD_BLANK = '{value: 16'hFFFF, default: '0};

    function automatic logic [7:0] seg_pattern(input logic [3:0] n);
        logic [7:0] p;
        case (n)
            4'h0:    p = 8'h3F;
            4'h1:    p = 8'h06;
            4'h2:    p = 8'h5B;
            4'h3:    p = 8'h4F;
            4'h4:    p = 8'h66;
            4'h5:    p = 8'h6D;
            4'h6:    p = 8'h7D;
            4'h7:    p = 8'h07;
            4'h8:    p = 8'h7F;
            4'h9:    p = 8'h6F;
            4'hA:    p = 8'h40;
            default: p = 8'h00;
        endcase
        return p;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    word_t         active_q, active_d;
    word_t         shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic          ack_q, ack_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    ena_q, ena_d;
`ifdef BLINK_EN
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
`endif

    logic       tick;
    logic       swap;
    word_t      in_word;
    logic [3:0] nib;
    logic [3:0] zero_above;
    logic [7:0] glyph;

    always_comb begin
        tick     = (presc_q == PW'(SCAN_DIV - 1));
        presc_d  = tick ? '0 : presc_q + PW'(1);
        idx_d    = tick ? idx_q + 2'd1 : idx_q;
        swap     = tick && (idx_q == 2'd3) && pending_q;

        in_word          = WORD_BLANK;
        in_word.value    = value;
        in_word.neg      = neg;
        in_word.dp       = dp;
        in_word.blank_lz = blank_lz;
`ifdef BLINK_EN
        in_word.blink    = blink;
`endif

        // Swap reads the pre-edge shadow, so a simultaneous load stays pending.
        active_d  = swap ? shadow_q : active_q;
        shadow_d  = load ? in_word : shadow_q;
        pending_d = load ? 1'b1 : (swap ? 1'b0 : pending_q);
        ack_d     = swap;

        zero_above[3] = (active_q.value[15:12] == 4'h0);
        zero_above[2] = zero_above[3] && (active_q.value[11:8] == 4'h0);
        zero_above[1] = zero_above[2] && (active_q.value[7:4] == 4'h0);
        zero_above[0] = 1'b0;

        nib   = active_q.value[{idx_q, 2'b00} +: 4];
        glyph = seg_pattern(nib);
        if (active_q.blank_lz && zero_above[idx_q]) begin
            glyph = 8'h00;
        end
        if (active_q.neg && (idx_q == 2'd3)) begin
            glyph = 8'h40;
        end
        glyph[7] = active_q.dp[idx_q];

`ifdef BLINK_EN
        // Phase flips every 256 ticks, i.e. every 64 frames.
        blink_cnt_d = tick ? blink_cnt_q + BW'(1) : blink_cnt_q;
        phase_d     = (tick && (blink_cnt_q == {BW{1'b1}})) ? ~phase_q : phase_q;
        if (phase_q && active_q.blink[idx_q]) begin
            glyph = 8'h00;
        end
`endif

        seg_d = glyph;
        ena_d = 4'b0001 << idx_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= 2'd0;
            active_q    <= WORD_BLANK;
            shadow_q    <= WORD_BLANK;
            pending_q   <= 1'b0;
            ack_q       <= 1'b0;
            seg_q       <= 8'h00;
            ena_q       <= 4'h0;
`ifdef BLINK_EN
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
`endif
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            active_q    <= active_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            ack_q       <= ack_d;
            seg_q       <= seg_d;
            ena_q       <= ena_d;
`ifdef BLINK_EN
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
`endif
        end
    end

    assign ack     = ack_q;
    assign pending = pending_q;
    assign seg     = seg_q;
    assign ena     = ena_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed handshake scenarios plus random loads,
// checked every cycle against a frame-arithmetic reference model.
module tb_seg_scan_driver;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;
    localparam logic [7:0] PAT [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                        8'h7F, 8'h6F, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic        neg = 1'b0;
    logic [3:0]  dp = 4'h0;
    logic        blank_lz = 1'b0;
    logic        ack;
    logic        pending;
    logic [7:0]  seg;
    logic [3:0]  ena;

    seg_scan_driver #(.SCAN_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .value    (value),
        .neg      (neg),
        .dp       (dp),
        .blank_lz (blank_lz),
`ifdef BLINK_EN
        .blink    (4'h0),
`endif
        .ack      (ack),
        .pending  (pending),
        .seg      (seg),
        .ena      (ena)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int ack_seen = 0;
    logic [7:0] dig_seg [4];

    // Reference model: visible word, shadow word, pending flag.
    logic [15:0] m_val, s_val;
    logic        m_neg, s_neg, m_blz, s_blz, m_pend;
    logic [3:0]  m_dp, s_dp;

    function automatic logic [7:0] ref_glyph(int d, logic [15:0] v, logic ng, logic [3:0] dpv, logic blz);
        logic [7:0]  g;
        logic [15:0] hi;
        hi = v >> (4 * d);
        g  = PAT[hi[3:0]];
        if (blz && d > 0 && hi == 16'h0) g = 8'h00;
        if (ng && d == 3) g = 8'h40;
        g[7] = dpv[d];
        return g;
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (n=%0d)", tag, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        n = 0;
        m_val = 16'hFFFF; m_neg = 1'b0; m_dp = 4'h0; m_blz = 1'b0;
        s_val = 16'hFFFF; s_neg = 1'b0; s_dp = 4'h0; s_blz = 1'b0;
        m_pend = 1'b0;
    endtask

    // One clock: model advances on the edge, outputs are checked 1 time unit later.
    task automatic cycle();
        int         idx;
        logic [7:0] e_seg;
        logic       e_ack;
        @(posedge clk);
        idx   = (n / DIV) % 4;
        e_seg = ref_glyph(idx, m_val, m_neg, m_dp, m_blz);
        e_ack = (n % FRAME == FRAME - 1) && m_pend;
        if (e_ack) begin
            m_val = s_val; m_neg = s_neg; m_dp = s_dp; m_blz = s_blz;
        end
        if (load) begin
            s_val = value; s_neg = neg; s_dp = dp; s_blz = blank_lz;
        end
        m_pend = load ? 1'b1 : (e_ack ? 1'b0 : m_pend);
        n++;
        #1;
        check("ena", 16'(ena), 16'(1 << idx));
        check("seg", 16'(seg), 16'(e_seg));
        check("ack", 16'(ack), 16'(e_ack));
        check("pending", 16'(pending), 16'(m_pend));
        dig_seg[idx] = seg;
        if (ack === 1'b1) ack_seen++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        #1;
        check("rst_seg", 16'(seg), 16'h0);
        check("rst_ena", 16'(ena), 16'h0);
        check("rst_ack", 16'(ack), 16'h0);
        check("rst_pending", 16'(pending), 16'h0);
        repeat (2) @(negedge clk);
        check("rst_hold_ena", 16'(ena), 16'h0);
        model_reset();
        rst = 1'b0;
    endtask

    task automatic align();
        while (n % FRAME != 0) cycle();
    endtask

    task automatic put(logic [15:0] v, logic ng, logic [3:0] d, logic blz);
        load = 1'b1; value = v; neg = ng; dp = d; blank_lz = blz;
    endtask

    task automatic check_digits(string tag, logic [7:0] d3, logic [7:0] d2, logic [7:0] d1, logic [7:0] d0);
        check({tag, "_d3"}, 16'(dig_seg[3]), 16'(d3));
        check({tag, "_d2"}, 16'(dig_seg[2]), 16'(d2));
        check({tag, "_d1"}, 16'(dig_seg[1]), 16'(d1));
        check({tag, "_d0"}, 16'(dig_seg[0]), 16'(d0));
    endtask

    initial begin
        model_reset();
        do_reset();

        // Idle scan after reset: blank, no ack.
        ack_seen = 0;
        repeat (5) cycle();

        // 0123 with blanking and dp on digit 2, loaded while idx=1.
        put(16'h0123, 1'b0, 4'b0100, 1'b1);
        cycle();
        load = 1'b0;
        check("idle_no_ack", 16'(ack_seen), 16'd0);
        repeat (10) cycle();
        check("w0123_ack", 16'(ack_seen), 16'd1);
        repeat (16) cycle();
        check_digits("w0123", 8'h00, 8'h86, 8'h5B, 8'h4F);

        // Two loads in one frame: last wins, single ack.
        align();
        ack_seen = 0;
        cycle();
        put(16'h0028, 1'b0, 4'h0, 1'b1);
        cycle();
        load = 1'b0;
        repeat (3) cycle();
        put(16'h0045, 1'b0, 4'h0, 1'b1);
        cycle();
        load = 1'b0;
        align();
        repeat (16) cycle();
        check("lastwins_ack", 16'(ack_seen), 16'd1);
        check_digits("lastwins", 8'h00, 8'h00, 8'h66, 8'h6D);

        // Load on the exact swap edge.
        align();
        put(16'h1234, 1'b0, 4'h0, 1'b0);
        cycle();
        load = 1'b0;
        while (n % FRAME != FRAME - 1) cycle();
        put(16'h5678, 1'b0, 4'h0, 1'b0);
        ack_seen = 0;
        cycle();
        load = 1'b0;
        check("swapload_ack", 16'(ack_seen), 16'd1);
        check("swapload_pending", 16'(pending), 16'd1);
        repeat (16) cycle();
        check_digits("swapload_first", 8'h06, 8'h5B, 8'h4F, 8'h66);
        check("swapload_ack2", 16'(ack_seen), 16'd2);
        check("swapload_pending2", 16'(pending), 16'd0);
        repeat (16) cycle();
        check_digits("swapload_second", 8'h6D, 8'h7D, 8'h07, 8'h7F);

        // Negative sign with blanking.
        align();
        put(16'h0007, 1'b1, 4'h0, 1'b1);
        cycle();
        load = 1'b0;
        align();
        repeat (16) cycle();
        check_digits("neg7", 8'h40, 8'h00, 8'h00, 8'h07);

        // Reset mid-frame with a pending word.
        put(16'h0999, 1'b0, 4'hF, 1'b0);
        cycle();
        load = 1'b0;
        repeat (3) cycle();
        check("pre_rst_pending", 16'(pending), 16'd1);
        do_reset();
        ack_seen = 0;
        repeat (40) cycle();
        check("post_rst_no_ack", 16'(ack_seen), 16'd0);
        check_digits("post_rst", 8'h00, 8'h00, 8'h00, 8'h00);

        // Random loads against the model.
        repeat (1200) begin
            if ($urandom_range(0, 11) == 0) begin
                put(16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
            end
            cycle();
            load = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
